// File: rtl/stream_mux_rr.sv
// ============================================================================
// Module   : stream_mux_rr
// Brief    : N-to-1 registered stream multiplexer with packet-locked grant.
//            Arbitration is round-robin (MODE 0) or fixed priority with the
//            lowest index winning (MODE 1). Once a beat without last is
//            accepted, the grant stays on that channel until its last beat.
//            Optional macro LOCK_TIMEOUT_EN adds lock_err and an idle counter
//            that releases a stalled lock after TIMEOUT empty cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux_rr #(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int MODE    = 0,
   parameter int TIMEOUT = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [N-1:0]                         in_valid,
   input  logic [N*W-1:0]                       in_data,
   input  logic [N-1:0]                         in_last,
   output logic [N-1:0]                         in_ready,
   output logic                                 out_valid,
   output logic [W-1:0]                         out_data,
   output logic                                 out_last,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_sel,
   input  logic                                 out_ready
`ifdef LOCK_TIMEOUT_EN
   ,
   output logic                                 lock_err
`endif
);

   localparam int c_SW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t          r_state;
   logic [c_SW-1:0] r_lock_ch;
   logic [c_SW-1:0] r_ptr;

   logic [c_SW-1:0] w_arb;
   logic            w_found;
   logic [c_SW-1:0] w_grant;
   logic            w_load;
   logic            w_xfer;
   logic [W-1:0]    w_sel_data;
   logic            w_sel_last;
   logic            w_lock_vld;

`ifdef LOCK_TIMEOUT_EN
   localparam int c_CW = $clog2(TIMEOUT + 1);
   logic [c_CW-1:0] r_idle_cnt;
`endif

   // Arbitration winner among asserted valids while no packet is locked.
   always_comb begin
      w_arb   = '0;
      w_found = 1'b0;
      if (MODE == 0) begin
         // Search starts one past the last packet owner and wraps around.
         for (int k = 1; k <= N; k++) begin
            if (!w_found && in_valid[(int'(r_ptr) + k) % N]) begin
               w_found = 1'b1;
               w_arb   = c_SW'((int'(r_ptr) + k) % N);
            end
         end
      end else begin
         // Descending scan so the lowest asserted index is the final winner.
         for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
               w_found = 1'b1;
               w_arb   = c_SW'(i);
            end
         end
      end
   end

   assign w_grant = (r_state == S_LOCKED) ? r_lock_ch : w_arb;
   assign w_load  = !out_valid || out_ready;

   // Ready is offered only to the granted channel; a locked channel sees it
   // even while it is momentarily not valid.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ready
         assign in_ready[gi] = w_load && (w_grant == c_SW'(gi)) &&
                               ((r_state == S_LOCKED) || in_valid[gi]);
      end
   endgenerate

   assign w_xfer = |(in_valid & in_ready);

   // Data/last of the granted channel and valid of the locked channel.
   always_comb begin
      w_sel_data = '0;
      w_sel_last = 1'b0;
      w_lock_vld = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (w_grant == c_SW'(i)) begin
            w_sel_data = in_data[i*W +: W];
            w_sel_last = in_last[i];
         end
         if (r_lock_ch == c_SW'(i)) begin
            w_lock_vld = in_valid[i];
         end
      end
   end

   // Output register stage plus packet-lock state machine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         out_sel    <= '0;
         r_state    <= S_IDLE;
         r_lock_ch  <= '0;
         r_ptr      <= c_SW'(N - 1);
`ifdef LOCK_TIMEOUT_EN
         r_idle_cnt <= '0;
         lock_err   <= 1'b0;
`endif
      end else begin
         if (w_load) begin
            out_valid <= w_xfer;
            if (w_xfer) begin
               out_data <= w_sel_data;
               out_last <= w_sel_last;
               out_sel  <= w_grant;
            end
         end
`ifdef LOCK_TIMEOUT_EN
         lock_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
`ifdef LOCK_TIMEOUT_EN
               r_idle_cnt <= '0;
`endif
               if (w_xfer) begin
                  if (w_sel_last) begin
                     r_ptr <= w_grant;
                  end else begin
                     r_state   <= S_LOCKED;
                     r_lock_ch <= w_grant;
                  end
               end
            end
            S_LOCKED: begin
               if (w_xfer && w_sel_last) begin
                  r_state <= S_IDLE;
                  r_ptr   <= w_grant;
               end
`ifdef LOCK_TIMEOUT_EN
               if (w_xfer) begin
                  r_idle_cnt <= '0;
               end else if (!w_lock_vld) begin
                  if (r_idle_cnt == c_CW'(TIMEOUT - 1)) begin
                     // Producer abandoned the packet: release the lock and
                     // move the pointer so another channel goes first.
                     r_idle_cnt <= '0;
                     r_state    <= S_IDLE;
                     r_ptr      <= r_lock_ch;
                     lock_err   <= 1'b1;
                  end else begin
                     r_idle_cnt <= r_idle_cnt + c_CW'(1);
                  end
               end
`else
               if (w_lock_vld) begin
                  r_lock_ch <= r_lock_ch;
               end
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
// ============================================================================
// Module   : tb_stream_mux_rr
// Brief    : Directed self-checking bench for stream_mux_rr. Instance dut0 is
//            round-robin, dut1 is fixed priority; both share the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux_rr;

   logic        clk;
   logic        rst_n;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_last;
   logic        out_ready;

   logic [3:0]  rdy0, rdy1;
   logic        ov0, ov1;
   logic [7:0]  od0, od1;
   logic        ol0, ol1;
   logic [1:0]  os0, os1;
`ifdef LOCK_TIMEOUT_EN
   logic        le0, le1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   stream_mux_rr #(.N(4), .W(8), .MODE(0), .TIMEOUT(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(rdy0), .out_valid(ov0), .out_data(od0),
      .out_last(ol0), .out_sel(os0), .out_ready(out_ready)
`ifdef LOCK_TIMEOUT_EN
      , .lock_err(le0)
`endif
   );

   stream_mux_rr #(.N(4), .W(8), .MODE(1), .TIMEOUT(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(rdy1), .out_valid(ov1), .out_data(od1),
      .out_last(ol1), .out_sel(os1), .out_ready(out_ready)
`ifdef LOCK_TIMEOUT_EN
      , .lock_err(le1)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      in_last   = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid c=%0d: got %b expected 0", c, ov0); end
         n_tests++; if (rdy0 !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready c=%0d: got %b expected 0000", c, rdy0); end
         n_tests++; if (os0 !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel c=%0d: got %0d expected 0", c, os0); end
         n_tests++; if (od0 !== 8'h00) begin n_fail++; $display("FAIL reset_out_data c=%0d: got %h expected 00", c, od0); end
      end
   endtask

   task automatic test_rr_single();
      in_valid  = 4'b1111;
      in_last   = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) in_data[i*8 +: 8] = 8'(8'hA0 + i);
      for (int k = 0; k < 8; k++) begin
         #1;
         n_tests++; if (rdy0 !== 4'(1 << (k % 4))) begin n_fail++; $display("FAIL rr_ready k=%0d: got %b expected %b", k, rdy0, 4'(1 << (k % 4))); end
         @(posedge clk); @(negedge clk);
         n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL rr_valid k=%0d: got %b expected 1", k, ov0); end
         n_tests++; if (od0 !== 8'(8'hA0 + k % 4)) begin n_fail++; $display("FAIL rr_data k=%0d: got %h expected %h", k, od0, 8'(8'hA0 + k % 4)); end
         n_tests++; if (os0 !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_sel k=%0d: got %0d expected %0d", k, os0, k % 4); end
      end
      in_valid = '0;
      @(posedge clk); @(negedge clk);
      n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL rr_drain_valid: got %b expected 0", ov0); end
   endtask

   task automatic test_packet();
      // ch1 single beat moves the round-robin pointer to 1.
      in_valid = 4'b0010; in_last = 4'b1111; in_data[15:8] = 8'h5A;
      @(posedge clk); @(negedge clk);
      n_tests++; if (od0 !== 8'h5A || os0 !== 2'd1) begin n_fail++; $display("FAIL pkt_pre: got %h/%0d expected 5A/1", od0, os0); end
      // ch0 and ch2 both valid: search from 2 picks ch2.
      in_valid = 4'b0101; in_data[7:0] = 8'hC0; in_last = 4'b1011; in_data[23:16] = 8'h11;
      #1;
      n_tests++; if (rdy0 !== 4'b0100) begin n_fail++; $display("FAIL pkt_ready_b0: got %b expected 0100", rdy0); end
      @(posedge clk); @(negedge clk);
      n_tests++; if (od0 !== 8'h11 || os0 !== 2'd2 || ol0 !== 1'b0) begin n_fail++; $display("FAIL pkt_beat0: got %h/%0d/%b expected 11/2/0", od0, os0, ol0); end
      in_data[23:16] = 8'h22;
      #1;
      n_tests++; if (rdy0 !== 4'b0100) begin n_fail++; $display("FAIL pkt_ready_b1: got %b expected 0100", rdy0); end
      @(posedge clk); @(negedge clk);
      n_tests++; if (od0 !== 8'h22 || os0 !== 2'd2 || ol0 !== 1'b0) begin n_fail++; $display("FAIL pkt_beat1: got %h/%0d/%b expected 22/2/0", od0, os0, ol0); end
      in_data[23:16] = 8'h33; in_last = 4'b1111;
      @(posedge clk); @(negedge clk);
      n_tests++; if (od0 !== 8'h33 || os0 !== 2'd2 || ol0 !== 1'b1) begin n_fail++; $display("FAIL pkt_beat2: got %h/%0d/%b expected 33/2/1", od0, os0, ol0); end
      in_valid = 4'b0001;
      #1;
      n_tests++; if (rdy0 !== 4'b0001) begin n_fail++; $display("FAIL pkt_ready_ch0: got %b expected 0001", rdy0); end
      @(posedge clk); @(negedge clk);
      n_tests++; if (od0 !== 8'hC0 || os0 !== 2'd0 || ov0 !== 1'b1) begin n_fail++; $display("FAIL pkt_ch0: got %h/%0d/%b expected C0/0/1", od0, os0, ov0); end
      in_valid = '0;
      @(posedge clk); @(negedge clk);
      n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL pkt_drain: got %b expected 0", ov0); end
   endtask

   task automatic test_back_pressure();
      logic [7:0] exp_d [9];
      logic [3:0] exp_r;
      int b;
      bit acc;
      exp_d = '{8'h31, 8'h32, 8'h32, 8'h32, 8'h32, 8'h32, 8'h32, 8'h33, 8'h34};
      b = 0;
      for (int c = 0; c < 10; c++) begin
         out_ready     = !(c >= 2 && c <= 6);
         in_valid      = (b < 4) ? 4'b0010 : 4'b0000;
         in_data[15:8] = 8'(8'h31 + b);
         in_last       = (b == 3) ? 4'b0010 : 4'b0000;
         exp_r         = ((c >= 2 && c <= 6) || c == 9) ? 4'b0000 : 4'b0010;
         #1;
         n_tests++; if (rdy0 !== exp_r) begin n_fail++; $display("FAIL bp_ready c=%0d: got %b expected %b", c, rdy0, exp_r); end
         acc = in_valid[1] && rdy0[1];
         @(posedge clk);
         if (acc) b++;
         @(negedge clk);
         n_tests++; if (ov0 !== (c < 9)) begin n_fail++; $display("FAIL bp_valid c=%0d: got %b expected %b", c, ov0, (c < 9)); end
         if (c < 9) begin
            n_tests++; if (od0 !== exp_d[c] || ol0 !== (c == 8)) begin n_fail++; $display("FAIL bp_data c=%0d: got %h/%b expected %h/%b", c, od0, ol0, exp_d[c], (c == 8)); end
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_fixed_priority();
      do_reset();
      in_valid = 4'b1010; in_last = 4'b1111;
      in_data[15:8] = 8'hB1; in_data[31:24] = 8'hB3;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_tests++; if (rdy1 !== 4'b0010) begin n_fail++; $display("FAIL fp_ready k=%0d: got %b expected 0010", k, rdy1); end
         @(posedge clk); @(negedge clk);
         n_tests++; if (od1 !== 8'hB1 || os1 !== 2'd1 || ov1 !== 1'b1) begin n_fail++; $display("FAIL fp_ch1 k=%0d: got %h/%0d/%b expected B1/1/1", k, od1, os1, ov1); end
      end
      in_valid = 4'b1000;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_tests++; if (rdy1 !== 4'b1000) begin n_fail++; $display("FAIL fp_ready3 k=%0d: got %b expected 1000", k, rdy1); end
         @(posedge clk); @(negedge clk);
         n_tests++; if (od1 !== 8'hB3 || os1 !== 2'd3) begin n_fail++; $display("FAIL fp_ch3 k=%0d: got %h/%0d expected B3/3", k, od1, os1); end
      end
      in_valid = 4'b1010;
      @(posedge clk); @(negedge clk);
      n_tests++; if (os1 !== 2'd1) begin n_fail++; $display("FAIL fp_back_to_ch1: got %0d expected 1", os1); end
      in_valid = '0;
      @(posedge clk); @(negedge clk);
      n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL fp_drain: got %b expected 0", ov1); end
   endtask

`ifdef LOCK_TIMEOUT_EN
   task automatic test_lock_timeout();
      do_reset();
      in_valid = 4'b0001; in_last = 4'b0000; in_data[7:0] = 8'hE0;
      @(posedge clk); @(negedge clk);
      n_tests++; if (od0 !== 8'hE0 || le0 !== 1'b0) begin n_fail++; $display("FAIL to_first: got %h/%b expected E0/0", od0, le0); end
      in_valid = 4'b0010; in_last = 4'b0010; in_data[15:8] = 8'hE1;
      for (int j = 1; j <= 16; j++) begin
         #1;
         n_tests++; if (rdy0 !== 4'b0001) begin n_fail++; $display("FAIL to_ready j=%0d: got %b expected 0001", j, rdy0); end
         @(posedge clk); @(negedge clk);
         n_tests++; if (le0 !== (j == 16)) begin n_fail++; $display("FAIL to_lock_err j=%0d: got %b expected %b", j, le0, (j == 16)); end
      end
      #1;
      n_tests++; if (rdy0 !== 4'b0010) begin n_fail++; $display("FAIL to_ready_ch1: got %b expected 0010", rdy0); end
      @(posedge clk); @(negedge clk);
      n_tests++; if (od0 !== 8'hE1 || os0 !== 2'd1 || le0 !== 1'b0) begin n_fail++; $display("FAIL to_ch1: got %h/%0d/%b expected E1/1/0", od0, os0, le0); end
      in_valid = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_rr_single();
      test_packet();
      test_back_pressure();
      test_fixed_priority();
`ifdef LOCK_TIMEOUT_EN
      test_lock_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
